// File: rtl/one_bit_alu_slice_pkg.sv
// Shared encodings for the one-bit ALU slice: op field values, control-bit
// positions and the named 4-bit control codes used by the ripple ALU.
package one_bit_alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  localparam int CON_AINV = 3;
  localparam int CON_BINV = 2;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_RSUB = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_NAND = 4'd13;

  // Bundle of the four values the slice registers each valid cycle.
  typedef struct packed {
    logic result;
    logic set;
    logic carryout;
    logic overflow;
  } alu_out_t;

endpackage

// File: rtl/one_bit_alu_slice_core.sv
// Combinational heart of the slice: operand inversion, full adder and op mux.
// No clock or reset; the top level registers everything this produces.
module one_bit_alu_core
  import one_bit_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic       less,
  input  logic [3:0] con,
  output logic       result,
  output logic       set,
  output logic       carryout,
  output logic       overflow
);

  logic a_inv;
  logic b_inv;

  assign a_inv = a ^ con[CON_AINV];
  assign b_inv = b ^ con[CON_BINV];

  // The adder runs for every op so the MSB slice always has set/overflow ready.
  assign set      = a_inv ^ b_inv ^ carryin;
  assign carryout = (a_inv & b_inv) | (a_inv & carryin) | (b_inv & carryin);
  assign overflow = carryin ^ carryout;

  always_comb begin
    result = 1'b0;
    case (con[1:0])
      OP_AND:  result = a_inv & b_inv;
      OP_OR:   result = a_inv | b_inv;
      OP_ADD:  result = set;
      OP_LESS: result = less;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/one_bit_alu_slice.sv
// Registered one-bit ALU slice with a valid qualifier and one cycle of latency.
// Define ONE_BIT_ALU_SLICE_STICKY_OVF_EN to add a clearable sticky overflow flag.
module one_bit_alu_slice
  import one_bit_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic       less,
  input  logic [3:0] con,
`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
  input  logic       sticky_clr,
  output logic       sticky_ovf,
`endif
  output logic       out_valid,
  output logic       result,
  output logic       set,
  output logic       carryout,
  output logic       overflow
);

  alu_out_t core_out;
  alu_out_t out_q;

  one_bit_alu_core u_core (
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .less     (less),
    .con      (con),
    .result   (core_out.result),
    .set      (core_out.set),
    .carryout (core_out.carryout),
    .overflow (core_out.overflow)
  );

  // Data only moves on valid cycles, so garbage on idle inputs never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_q <= core_out;
    end
  end

  assign result   = out_q.result;
  assign set      = out_q.set;
  assign carryout = out_q.carryout;
  assign overflow = out_q.overflow;

`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
  // Clear wins over a same-cycle overflow so software never loses a fresh clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                sticky_ovf <= 1'b0;
    else if (sticky_clr)                       sticky_ovf <= 1'b0;
    else if (in_valid && core_out.overflow)    sticky_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_one_bit_alu_slice.sv
// Directed, table-driven bench for one_bit_alu_slice, plus hand-written
// handshake/reset sequences and the sticky overflow flag when it is built in.
module tb_one_bit_alu_slice;
  import one_bit_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       a, b, carryin, less;
  logic [3:0] con;
  logic       out_valid, result, set, carryout, overflow;
`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
  logic       sticky_clr;
  logic       sticky_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] con;
    logic       a, b, cin, less;
    logic       exp_r, exp_s, exp_co, exp_ov;
  } vec_t;

  vec_t vecs[$];

  one_bit_alu_slice dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .carryin    (carryin),
    .less       (less),
    .con        (con),
`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
`endif
    .out_valid  (out_valid),
    .result     (result),
    .set        (set),
    .carryout   (carryout),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic [3:0] c, logic va, logic vb, logic vc,
                              logic vl, logic r, logic s, logic co, logic ov);
    vec_t v;
    v.name = name; v.con = c; v.a = va; v.b = vb; v.cin = vc; v.less = vl;
    v.exp_r = r; v.exp_s = s; v.exp_co = co; v.exp_ov = ov;
    return v;
  endfunction

  // Reference for the logic-op sweep: arithmetic add of the inverted operands
  // and De Morgan forms of the named logic ops.
  function automatic vec_t model(string name, logic [3:0] c, logic va, logic vb, logic vc);
    logic [1:0] total;
    logic ap, bp, r;
    ap = va ^ c[3];
    bp = vb ^ c[2];
    total = {1'b0, ap} + {1'b0, bp} + {1'b0, vc};
    case (c)
      ALU_AND:  r = va & vb;
      ALU_OR:   r = va | vb;
      ALU_NAND: r = ~(va & vb);
      ALU_NOR:  r = ~(va | vb);
      default:  r = 1'bx;
    endcase
    return mk(name, c, va, vb, vc, 1'b0, r, total[0], total[1], total[1] ^ vc);
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic v, input logic r,
                             input logic s, input logic co, input logic ov);
    checkBit({name, ".out_valid"}, out_valid, v);
    checkBit({name, ".result"},    result,    r);
    checkBit({name, ".set"},       set,       s);
    checkBit({name, ".carryout"},  carryout,  co);
    checkBit({name, ".overflow"},  overflow,  ov);
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = 1'b1;
    con = v.con; a = v.a; b = v.b; carryin = v.cin; less = v.less;
    @(posedge clk);
    #1;
  endtask

  initial begin
    string nm[4];
    logic [3:0] cd[4];
    nm = '{"and", "or", "nand", "nor"};
    cd = '{ALU_AND, ALU_OR, ALU_NAND, ALU_NOR};

    // name, con, a, b, cin, less, result, set, carryout, overflow
    vecs.push_back(mk("add_001",  ALU_ADD,  0, 0, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk("add_110",  ALU_ADD,  1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("add_101",  ALU_ADD,  1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("sub_000",  ALU_SUB,  0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("sub_011",  ALU_SUB,  0, 1, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk("rsub_101", ALU_RSUB, 1, 0, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk("nand_110", ALU_NAND, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("nor_000",  ALU_NOR,  0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk("nand_001", ALU_NAND, 0, 0, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk("slt_l0",   ALU_SLT,  1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("slt_l1",   ALU_SLT,  1, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("slt_110",  ALU_SLT,  1, 1, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk("slt_011",  ALU_SLT,  0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("or_010",   ALU_OR,   0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("and_110",  ALU_AND,  1, 1, 0, 0, 1, 0, 1, 1));
    for (int op = 0; op < 4; op++)
      for (int k = 0; k < 8; k++)
        vecs.push_back(model($sformatf("%s_%0d", nm[op], k), cd[op], k[2], k[1], k[0]));

    rst_n = 1'b0; in_valid = 1'b0;
    a = 0; b = 0; carryin = 0; less = 0; con = 4'd0;
`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    #1;
    checkOutput("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table vectors, one result per cycle.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, 1, vecs[i].exp_r, vecs[i].exp_s, vecs[i].exp_co, vecs[i].exp_ov);
    end

    // Idle cycles with unknown operands must hold the last data.
    applyStimulus(mk("pre_hold", ALU_ADD, 0, 0, 1, 0, 1, 1, 0, 1));
    checkOutput("pre_hold", 1, 1, 1, 0, 1);
    in_valid = 1'b0; a = 1'bx; b = 1'bx; carryin = 1'bx; con = 4'bxxxx;
    @(posedge clk); #1;
    checkOutput("hold1", 0, 1, 1, 0, 1);
    @(posedge clk); #1;
    checkOutput("hold2", 0, 1, 1, 0, 1);

    // Asynchronous reset in the middle of a stream.
    applyStimulus(mk("pre_rst", ALU_ADD, 1, 1, 0, 0, 0, 0, 1, 1));
    checkOutput("pre_rst", 1, 0, 0, 1, 1);
    con = ALU_NOR; a = 0; b = 0; carryin = 0; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("rst_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk("post_rst", ALU_ADD, 0, 0, 1, 0, 1, 1, 0, 1));
    checkOutput("post_rst", 1, 1, 1, 0, 1);

`ifdef ONE_BIT_ALU_SLICE_STICKY_OVF_EN
    // Sticky flag: set by overflow, survives clean ops, clear beats set.
    in_valid = 1'b0; sticky_clr = 1'b1;
    @(posedge clk); #1;
    checkBit("sticky_cleared", sticky_ovf, 1'b0);
    sticky_clr = 1'b0;
    applyStimulus(mk("st_set", ALU_ADD, 0, 0, 1, 0, 1, 1, 0, 1));
    checkBit("sticky_set", sticky_ovf, 1'b1);
    applyStimulus(mk("st_and", ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0));
    checkBit("sticky_hold_and", sticky_ovf, 1'b1);
    applyStimulus(mk("st_or", ALU_OR, 0, 1, 0, 0, 1, 1, 0, 0));
    checkBit("sticky_hold_or", sticky_ovf, 1'b1);
    sticky_clr = 1'b1;
    applyStimulus(mk("st_clr", ALU_ADD, 0, 0, 1, 0, 1, 1, 0, 1));
    checkBit("sticky_clr_priority", sticky_ovf, 1'b0);
    sticky_clr = 1'b0;
    applyStimulus(mk("st_reset", ALU_ADD, 1, 1, 0, 0, 0, 0, 1, 1));
    checkBit("sticky_reset_pre", sticky_ovf, 1'b1);
    rst_n = 1'b0; #1;
    checkBit("sticky_async_rst", sticky_ovf, 1'b0);
    rst_n = 1'b1;
`endif

    in_valid = 1'b0;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/one_bit_alu_slice.md
Name: one_bit_alu_slice

Overview:
- Registered single-bit ALU slice, intended to be cascaded into an N-bit ripple ALU in MIPS style.
- Supports AND, OR, NAND, NOR, ADD, SUB (a-b), reverse SUB (b-a) and SLT, all encoded by a 4-bit control word.
- Combinational slice logic feeds an output register: one clock of latency, with a valid qualifier.
- Set and overflow outputs exist for use by the most-significant slice; the SLT result comes in on the less input from the MSB slice's set.

Parameters:
- None. Width is fixed at 1 bit; control is fixed at 4 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and control are valid this cycle; capture them
- a  in  1  operand A
- b  in  1  operand B
- carryin  in  1  carry into this slice (1 for LSB of SUB)
- less  in  1  value returned as result for SLT (MSB set, wired back to LSB)
- con  in  4  [3]=ainvert, [2]=binvert, [1:0]=op (00 AND, 01 OR, 10 ADD, 11 LESS)
- out_valid  out  1  registered outputs updated from a valid input
- result  out  1  registered ALU result
- set  out  1  registered raw adder sum (a'^b'^carryin)
- carryout  out  1  registered adder carry-out
- overflow  out  1  registered carryin XOR carryout

Behaviour:
- Combinational core:
  - a' = a ^ con[3]; b' = b ^ con[2].
  - sum = a'^b'^carryin; cout = a'b' | a'carryin | b'carryin.
  - ovf = carryin ^ cout.
  - op 00: a'&b'. op 01: a'|b'. op 10: sum. op 11: less.
- set, carryout and overflow are always computed from the adder, whatever the op.
- Named codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 10 reverse SUB (~a+b+cin), 3 SLT, 12 NOR (~a&~b), 13 NAND (~a|~b).
  - All 16 codes are legal and follow the bit fields; no illegal-code handling.
- Register stage:
  - On a rising clk edge with in_valid=1, result/set/carryout/overflow load the core values and out_valid<=1.
  - With in_valid=0, the data outputs hold their last values and out_valid<=0.
- Latency is exactly one cycle. Back-to-back valid inputs produce back-to-back outputs; there is no stall or backpressure.
- Reset: rst_n low asynchronously clears result, set, carryout, overflow and out_valid to 0. Release is sampled on the next clk edge.
- Reset asserted mid-operation discards the in-flight value; the first valid output after reset comes from the first in_valid sampled after release.
- X on inputs with in_valid=0 must not disturb the held outputs.

Optional Feature:
- Macro ONE_BIT_ALU_SLICE_STICKY_OVF_EN.
- Defined:
  - Adds input sticky_clr (1 bit) and output sticky_ovf (1 bit), both registered.
  - sticky_ovf sets on any valid cycle whose overflow=1 and reset-clears to 0.
  - sticky_clr=1 clears it on the next edge; clear takes priority over a simultaneous set.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package one_bit_alu_pkg holds:
  - op localparams OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_LESS=2'b11;
  - bit indices CON_AINV=3, CON_BINV=2;
  - named 4-bit codes ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLT=3, ALU_SUB=6, ALU_RSUB=10, ALU_NOR=12, ALU_NAND=13.
- One combinational sub-module, one_bit_alu_core: inversion, full adder and op mux. It has no clock and no reset.
- The top level adds the register stage and the optional sticky logic.

Test Plan:
- AND, OR, NAND, NOR: sweep all 8 (a,b,carryin) combinations with in_valid=1, checking result one cycle later.
  - NAND a=1,b=1 -> 0.
  - NOR a=0,b=0 -> 1.
  - Carryout follows the inverted-operand adder, e.g. NAND a=0,b=0,cin=1 -> carryout=1.
- ADD:
  - a=0,b=0,cin=1 -> result=1, set=1, carryout=0, overflow=1.
  - a=1,b=1,cin=0 -> result=0, carryout=1, overflow=1.
  - a=1,b=0,cin=1 -> result=0, carryout=1, overflow=0.
- SUB (6):
  - a=0,b=0,cin=0 -> result=1, carryout=0, overflow=0.
  - a=0,b=1,cin=1 -> result=1, carryout=0, overflow=1.
  - Reverse SUB (10) with a=1,b=0,cin=1 -> result=1, overflow=1.
- SLT (3):
  - less=0 -> result=0 and less=1 -> result=1, regardless of a/b.
  - set still equals a^b^cin, e.g. a=1,b=0,cin=0 -> set=1.
- Handshake/reset:
  - in_valid low holds outputs, with out_valid=0 the following cycle.
  - rst_n low mid-stream clears all outputs immediately without waiting for clk.
  - The first valid input after release appears one cycle later.
- With ONE_BIT_ALU_SLICE_STICKY_OVF_EN:
  - ADD 0+0+1 sets sticky_ovf=1, and it stays 1 through subsequent non-overflow ops.
  - sticky_clr together with an overflowing op -> sticky_ovf=0.
